// File: rtl/alu_mul_seq.sv
// alu_mul_seq: low 64 bits of a*b by sequencing MULW/SHL/ADD ops through an external ALU.
// Optional build macro ALU_MUL_SEQ_SKIP_ZERO_EN skips partial products that have a zero chunk.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [3:0]  alu_op,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic [63:0] alu_s
);
  localparam int WIDTH = 64;
  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SHL = 4'd6, ALU_MULW = 4'd9;
  // Chunk indices (i, j) of the 10 pairs with i+j<=3, pair 0 in the low bits; padded to 16 entries
  localparam logic [31:0] PI = {12'b0, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [31:0] PJ = {12'b0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [3:0] NONE = 4'd10;
  typedef enum logic [2:0] {IDLE, MUL, SHL, ADD, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] ra, rb, tmp, sum;
  logic [9:0] mask, in_mask;
  logic [3:0] k, first, nk;
  logic [1:0] ci, cj;
  logic accept;
  function automatic logic [3:0] next_pair(input logic [9:0] m, input logic [3:0] from);
    logic [3:0] n;
    n = NONE;
    for (int p = 9; p >= 0; p--)
      if (m[p] && 4'(p) >= from) n = 4'(p);
    return n;
  endfunction
`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
  always_comb begin
    in_mask = '0;
    for (int p = 0; p < 10; p++)
      in_mask[p] = (|a[{PI[2*p +: 2], 4'b0} +: 16]) && (|b[{PJ[2*p +: 2], 4'b0} +: 16]);
  end
`else
  assign in_mask = '1;
`endif
  assign first = next_pair(in_mask, 4'd0);
  assign nk = next_pair(mask, k + 4'd1);
  assign ci = PI[{k, 1'b0} +: 2];
  assign cj = PJ[{k, 1'b0} +: 2];
  assign accept = start && (state == IDLE || state == DONE);
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    busy = 1'b0;
    done = 1'b0;
    alu_op = ALU_NOP;
    alu_a = '0;
    alu_b = '0;
    case (state)
      IDLE, DONE: begin
        done = state == DONE;
        nxt = accept ? (first == NONE ? DONE : MUL) : IDLE;
      end
      MUL: begin
        busy = 1'b1;
        alu_op = ALU_MULW;
        alu_a = {48'b0, ra[{ci, 4'b0} +: 16]};
        alu_b = {48'b0, rb[{cj, 4'b0} +: 16]};
        nxt = SHL;
      end
      SHL: begin
        busy = 1'b1;
        alu_op = ALU_SHL;
        alu_a = {58'b0, ci + cj, 4'b0};
        alu_b = tmp;
        nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        alu_op = ALU_ADD;
        alu_a = tmp;
        alu_b = sum;
        nxt = nk == NONE ? DONE : MUL;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
      tmp <= '0;
      sum <= '0;
      mask <= '0;
      k <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        ra <= a;
        rb <= b;
        sum <= '0;
        mask <= in_mask;
        k <= first;
        if (first == NONE) result <= '0;
      end
      if (state == MUL || state == SHL) tmp <= alu_s;
      if (state == ADD) begin
        sum <= alu_s;
        k <= nk;
        if (nk == NONE) result <= alu_s;
      end
    end
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed and random products of alu_mul_seq against plain a*b, with a behavioural ALU.
module tb_alu_mul_seq;
  logic clk = 1'b0, rst, start;
  logic [63:0] a, b, result, alu_a, alu_b, alu_s;
  logic busy, done;
  logic [3:0] alu_op;
  int compared = 0, mismatched = 0;
`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SHL = 4'd6, OP_MULW = 4'd9;

  alu_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_s = '0;
    case (alu_op)
      OP_MULW: alu_s = alu_a * alu_b;
      OP_SHL:  alu_s = alu_b << alu_a[5:0];
      OP_ADD:  alu_s = alu_a + alu_b;
      default: alu_s = '0;
    endcase
  end

  function automatic int n_pairs(input logic [63:0] x, input logic [63:0] y);
    int n = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j + i < 4; j++)
        if (!SKIP || (x[16*i +: 16] != 0 && y[16*j +: 16] != 0)) n++;
    return n;
  endfunction

  function automatic logic [3:0] exp_op(input int phase);
    return phase == 0 ? OP_MULW : phase == 1 ? OP_SHL : OP_ADD;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [63:0] x, input logic [63:0] y, input bit pester, input string tag);
    int lat, bsy, opbad, n;
    n = n_pairs(x, y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    lat = 1;
    bsy = 0;
    opbad = 0;
    while (!done && lat < 200) begin
      if (busy) begin
        if (alu_op !== exp_op(bsy % 3)) opbad++;
        bsy++;
      end
      start = pester && busy && (lat == 5 || lat == 20);
      if (start) begin
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(3 * n + 1));
    check({tag, " busy cycles"}, 64'(bsy), 64'(3 * n));
    check({tag, " op sequence"}, 64'(opbad), 64'd0);
    check({tag, " result"}, result, x * y);
    @(negedge clk);
    check({tag, " done single pulse"}, {63'b0, done}, 64'd0);
    check({tag, " idle op"}, {60'b0, alu_op}, {60'b0, OP_NOP});
    check({tag, " result held"}, result, x * y);
  endtask

  initial begin
    logic [63:0] x, y;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset done", {63'b0, done}, 64'd0);
    check("reset result", result, 64'd0);
    check("reset op", {60'b0, alu_op}, {60'b0, OP_NOP});
    check("reset alu_a", alu_a, 64'd0);
    check("reset alu_b", alu_b, 64'd0);
    rst = 1'b0;
    run(64'd3, 64'd5, 1'b0, "3x5");
    run('1, '1, 1'b0, "all ones wrap");
    run(64'h1_0000, 64'h1_0000, 1'b0, "2^16 squared");
    run(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, "mixed");
    run(64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 1'b1, "ignored starts");
    @(negedge clk);
    a = 64'hFFFF_0001_8000_7FFF;
    b = 64'h1111_2222_3333_4444;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {63'b0, busy}, 64'd0);
    check("abort done", {63'b0, done}, 64'd0);
    check("abort result", result, 64'd0);
    check("abort op", {60'b0, alu_op}, {60'b0, OP_NOP});
    run(64'h0000_0007_0000_0009, 64'h0003_0000_0000_0002, 1'b0, "after abort");
    run(64'd0, 64'd7, 1'b0, "zero operand");
    run(64'h1_0000, 64'd3, 1'b0, "single pair");
    for (int t = 0; t < 6; t++) begin
      x = {$urandom(), $urandom()};
      y = {$urandom(), $urandom()};
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 2) == 0) x[16*c +: 16] = '0;
        if ($urandom_range(0, 2) == 0) y[16*c +: 16] = '0;
      end
      run(x, y, t[0], $sformatf("random %0d", t));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
